next_pc_unit: RTL and testbench
===============================

// Module: next_pc_unit
// PURPOSE
//  Parametrised successor to the combinational next-instruction selector.
//  Owns the registered program counter and resolves the next fetch address from direct, register
//  and flag-conditional branches. Adds stall and pending-redirect capture, plus a call/return
//  address stack (RAS). Sits between decode/ALU flags and instruction memory address.
// PARAMETERS
//  PC_W        32            width of PC and all target/return addresses
//  RESET_PC    32'h0000_0000 PC value after reset
//  INSTR_BYTES 4             sequential increment; targets have low $clog2(INSTR_BYTES) bits cleared
//  RAS_DEPTH   8             return-stack entries (power of 2, >=2)
// PORTS
//  clk            in   1     clock, rising edge
//  rst            in   1     synchronous reset, active-high
//  stall          in   1     hold PC this cycle
//  instr_valid    in   1     branch/flag inputs valid this cycle
//  branch         in   3     000 seq, 001 direct, 010 register, 011 bltz(sign), 100 bz(zero),
//                            101 bnz(!zero), 110 bcy(carry), 111 bncy(!carry)
//  is_call        in   1     push return address (with branch 001 or 010)
//  is_ret         in   1     target = RAS top (pop)
//  carry,zero,sign in  1     ALU flags
//  imm_target     in   PC_W  direct / conditional target
//  rs_val         in   PC_W  register target
//  pc             out  PC_W  current fetch address (registered)
//  taken          out  1     comb: current instr redirects (branch!=000 and condition true, or is_ret)
//  flush          out  1     registered 1-cycle pulse: redirect applied, discard fetched instr
//  ras_empty      out  1     comb: stack count == 0
//  ras_overflow   out  1     sticky: push occurred while full; cleared by rst only
//  ras_underflow  out  1     registered 1-cycle pulse: pop on empty
//  stat_branches  out  32    conditional branches seen (see CONFIGURATION)
//  stat_taken     out  32    conditional branches taken
// BEHAVIOUR
//  - Reset: pc=RESET_PC; flush=0; ras_underflow=0; ras_overflow=0; RAS count=0; pending=0; stats=0.
//  - seq = pc+INSTR_BYTES (mod 2^PC_W; wrap silently). target = align(selected source).
//  - Priority of source, highest first: is_ret -> RAS top; 001 -> imm_target; 010 -> rs_val;
//    conditional true -> imm_target; otherwise seq. instr_valid=0 => seq, no RAS op, no stats.
//  - !stall, no pending: pc <= taken ? target : seq; flush <= taken. Latency 1 cycle.
//  - stall: pc holds. If instr_valid&&taken and no pending, capture target and set pending.
//    RAS ops are also performed in the capture cycle. Further redirects while pending are ignored.
//  - First !stall cycle with pending: pc <= pending target; flush<=1; pending<=0.
//    Current-cycle inputs are ignored (no RAS op, no stats).
//  - Call (is_call, taken): push pc+INSTR_BYTES.
//    When full, overwrite oldest (circular) and set ras_overflow; count saturates at RAS_DEPTH.
//  - Ret: pop. On empty, target = rs_val, ras_underflow pulses next cycle, count stays 0.
//  - is_call&&is_ret: pop top as target, then write the return address into the freed slot.
//    Count is unchanged; on empty this behaves as push plus underflow.
//  - rst mid-stall discards pending and RAS contents.
// CONFIGURATION
//  NPC_BRANCH_STATS_EN defined:
//   - stat_branches increments on each accepted instr with branch in 011..111.
//   - stat_taken increments on those taken. Both wrap at 2^32.
//   - An accepted instr is instr_valid and (!stall, or stall with no pending).
//  NPC_BRANCH_STATS_EN undefined: counters are not built; stat_* tied to 0. Ports remain.
// TESTING
//  - rst 1 cycle, then 3 cycles branch=000 -> pc 0x0,0x4,0x8,0xC; flush=0.
//  - pc=0x10, branch=100, zero=1, imm_target=0x43 -> next pc=0x40, flush=1 for one cycle.
//    Same with zero=0 -> pc=0x14.
//  - Call at pc=0x20 (001, imm 0x100), then ret at 0x104 -> pc 0x100 then 0x24; ras_empty=1 after.
//  - RAS_DEPTH+1 calls, then RAS_DEPTH+1 rets -> ras_overflow=1.
//    Rets return the newest RAS_DEPTH addresses; the last ret uses rs_val with ras_underflow=1.
//  - stall=1 with 010, rs_val=0x200 at pc=0x30, stall held 3 cycles (new branches ignored)
//    -> pc stays 0x30; pc=0x200 one cycle after release.
//  - NPC_BRANCH_STATS_EN: 5 conditional (3 taken) plus 2 direct -> stat_branches=5, stat_taken=3.

Source files
------------

// File: rtl/next_pc_unit.sv
// next_pc_unit: registered PC with branch resolution, stall/pending redirect and a circular return stack; NPC_BRANCH_STATS_EN builds branch counters
module next_pc_unit #(
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int INSTR_BYTES = 4,
  parameter int RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            instr_valid,
  input  logic [2:0]      branch,
  input  logic            is_call,
  input  logic            is_ret,
  input  logic            carry,
  input  logic            zero,
  input  logic            sign,
  input  logic [PC_W-1:0] imm_target,
  input  logic [PC_W-1:0] rs_val,
  output logic [PC_W-1:0] pc,
  output logic            taken,
  output logic            flush,
  output logic            ras_empty,
  output logic            ras_overflow,
  output logic            ras_underflow,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken
);
  localparam int AW = $clog2(RAS_DEPTH);
  localparam logic [PC_W-1:0] MASK = ~(PC_W'(INSTR_BYTES - 1));
  localparam logic [AW:0] FULL = (AW + 1)'(RAS_DEPTH);
  logic [PC_W-1:0] ras [RAS_DEPTH];
  logic [AW-1:0]   sp;
  logic [AW:0]     cnt;
  logic            pend;
  logic [PC_W-1:0] pend_pc;
  logic [PC_W-1:0] seq;
  logic [PC_W-1:0] tgt;
  logic            cond;
  logic            accept;
  logic            push;
  logic            pop;
  // branch condition, redirect target and stack operation decode
  always_comb begin
    seq = pc + PC_W'(INSTR_BYTES);
    ras_empty = cnt == '0;
    cond = (branch == 3'b001) || (branch == 3'b010) || (branch == 3'b011 && sign) ||
           (branch == 3'b100 && zero) || (branch == 3'b101 && !zero) ||
           (branch == 3'b110 && carry) || (branch == 3'b111 && !carry);
    taken = instr_valid && (is_ret || cond);
    accept = instr_valid && !pend;
    pop = accept && is_ret;
    push = accept && is_call && taken;
    tgt = MASK & (is_ret ? (ras_empty ? rs_val : ras[sp - AW'(1)]) :
                  branch == 3'b010 ? rs_val : imm_target);
  end
  // pc update, flush pulse and capture of redirects arriving under stall
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      flush <= 1'b0;
      pend <= 1'b0;
      pend_pc <= '0;
    end else if (pend && !stall) begin
      pc <= pend_pc;
      flush <= 1'b1;
      pend <= 1'b0;
    end else if (!stall) begin
      pc <= taken ? tgt : seq;
      flush <= taken;
    end else begin
      flush <= 1'b0;
      if (taken && !pend) begin
        pend <= 1'b1;
        pend_pc <= tgt;
      end
    end
  end
  // stack pointer, occupancy and over/underflow flags; a full push lands on the oldest slot
  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
      cnt <= '0;
      ras_overflow <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      ras_underflow <= pop && ras_empty;
      if (push && !(pop && !ras_empty)) begin
        sp <= sp + AW'(1);
        cnt <= cnt == FULL ? cnt : cnt + 1'b1;
        if (cnt == FULL) ras_overflow <= 1'b1;
      end else if (pop && !push && !ras_empty) begin
        sp <= sp - AW'(1);
        cnt <= cnt - 1'b1;
      end
    end
  end
  // stack storage; call+ret reuses the slot just popped
  always_ff @(posedge clk) begin
    if (!rst && push) ras[(pop && !ras_empty) ? sp - AW'(1) : sp] <= seq;
  end
`ifdef NPC_BRANCH_STATS_EN
  // conditional branch counters over accepted instructions
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches <= '0;
      stat_taken <= '0;
    end else if (accept && branch >= 3'b011) begin
      stat_branches <= stat_branches + 32'd1;
      stat_taken <= stat_taken + {31'd0, taken};
    end
  end
`else
  assign stat_branches = '0;
  assign stat_taken = '0;
`endif
endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit: directed self-checking bench for next_pc_unit
module tb_next_pc_unit;
  logic clk = 1'b0;
  logic rst, stall, instr_valid, is_call, is_ret, carry, zero, sign;
  logic [2:0] branch;
  logic [31:0] imm_target, rs_val, pc, stat_branches, stat_taken;
  logic taken, flush, ras_empty, ras_overflow, ras_underflow;
  int checks = 0;
  int fails = 0;

  next_pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .instr_valid(instr_valid), .branch(branch),
    .is_call(is_call), .is_ret(is_ret), .carry(carry), .zero(zero), .sign(sign),
    .imm_target(imm_target), .rs_val(rs_val), .pc(pc), .taken(taken), .flush(flush),
    .ras_empty(ras_empty), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow),
    .stat_branches(stat_branches), .stat_taken(stat_taken)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; instr_valid = 0; branch = 3'b000; is_call = 0; is_ret = 0;
    carry = 0; zero = 0; sign = 0; imm_target = 0; rs_val = 0;
  endtask

  task automatic drive(input logic [2:0] b, input logic [31:0] imm, input logic [31:0] rs,
                       input logic c, input logic r);
    instr_valid = 1; branch = b; imm_target = imm; rs_val = rs; is_call = c; is_ret = r;
  endtask

  task automatic jump(input logic [31:0] a);
    drive(3'b001, a, 0, 0, 0);
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    checks++; if (flush !== 1'b0) begin fails++; $display("FAIL reset_flush: got %b expected 0", flush); end
    checks++; if (ras_empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b expected 1", ras_empty); end
    checks++; if (ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin fails++; $display("FAIL reset_ras_flags: got %b%b expected 00", ras_overflow, ras_underflow); end
    checks++; if (stat_branches !== 0 || stat_taken !== 0) begin fails++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_branches, stat_taken); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (pc !== 32'(4 * i) || flush !== 1'b0) begin fails++; $display("FAIL seq_%0d: got pc %h flush %b expected pc %h flush 0", i, pc, flush, 32'(4 * i)); end
    end
  endtask

  task automatic test_cond();
    tick();
    checks++; if (pc !== 32'h10) begin fails++; $display("FAIL cond_start: got %h expected 10", pc); end
    drive(3'b100, 32'h43, 0, 0, 0);
    zero = 1;
    #1;
    checks++; if (taken !== 1'b1) begin fails++; $display("FAIL bz_taken_comb: got %b expected 1", taken); end
    tick();
    checks++; if (pc !== 32'h40 || flush !== 1'b1) begin fails++; $display("FAIL bz_taken: got pc %h flush %b expected 40/1", pc, flush); end
    idle();
    tick();
    checks++; if (pc !== 32'h44 || flush !== 1'b0) begin fails++; $display("FAIL bz_after: got pc %h flush %b expected 44/0", pc, flush); end
    jump(32'h10);
    drive(3'b100, 32'h43, 0, 0, 0);
    #1;
    checks++; if (taken !== 1'b0) begin fails++; $display("FAIL bz_not_taken_comb: got %b expected 0", taken); end
    tick();
    checks++; if (pc !== 32'h14 || flush !== 1'b0) begin fails++; $display("FAIL bz_not_taken: got pc %h flush %b expected 14/0", pc, flush); end
    drive(3'b001, 32'h900, 0, 0, 0);
    instr_valid = 0;
    #1;
    checks++; if (taken !== 1'b0) begin fails++; $display("FAIL invalid_taken: got %b expected 0", taken); end
    tick();
    checks++; if (pc !== 32'h18) begin fails++; $display("FAIL invalid_seq: got %h expected 18", pc); end
    idle();
  endtask

  task automatic test_call_ret();
    jump(32'h20);
    drive(3'b001, 32'h100, 0, 1, 0);
    tick();
    checks++; if (pc !== 32'h100 || ras_empty !== 1'b0) begin fails++; $display("FAIL call: got pc %h empty %b expected 100/0", pc, ras_empty); end
    idle();
    tick();
    drive(3'b000, 0, 32'h777, 0, 1);
    tick();
    checks++; if (pc !== 32'h24 || flush !== 1'b1) begin fails++; $display("FAIL ret: got pc %h flush %b expected 24/1", pc, flush); end
    idle();
    #1;
    checks++; if (ras_empty !== 1'b1) begin fails++; $display("FAIL ret_empty: got %b expected 1", ras_empty); end
  endtask

  task automatic test_ras_overflow();
    jump(32'h1000);
    for (int k = 0; k < 9; k++) begin
      drive(3'b001, 32'h1000 + 32'h100 * (k + 1), 0, 1, 0);
      tick();
    end
    idle();
    checks++; if (pc !== 32'h1900 || ras_overflow !== 1'b1) begin fails++; $display("FAIL ovf_calls: got pc %h ovf %b expected 1900/1", pc, ras_overflow); end
    for (int j = 0; j < 8; j++) begin
      drive(3'b000, 0, 32'h3000, 0, 1);
      tick();
      checks++; if (pc !== 32'h1000 + 32'h100 * (8 - j) + 4) begin fails++; $display("FAIL ovf_ret_%0d: got %h expected %h", j, pc, 32'h1000 + 32'h100 * (8 - j) + 4); end
    end
    checks++; if (ras_underflow !== 1'b0) begin fails++; $display("FAIL early_underflow: got %b expected 0", ras_underflow); end
    drive(3'b000, 0, 32'h3000, 0, 1);
    tick();
    checks++; if (pc !== 32'h3000 || ras_underflow !== 1'b1) begin fails++; $display("FAIL underflow_ret: got pc %h unf %b expected 3000/1", pc, ras_underflow); end
    idle();
    tick();
    checks++; if (ras_underflow !== 1'b0 || ras_overflow !== 1'b1 || ras_empty !== 1'b1) begin fails++; $display("FAIL after_underflow: got unf %b ovf %b empty %b expected 0/1/1", ras_underflow, ras_overflow, ras_empty); end
  endtask

  task automatic test_stall();
    jump(32'h30);
    stall = 1;
    drive(3'b010, 0, 32'h200, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 32'h30 || flush !== 1'b0) begin fails++; $display("FAIL stall_hold_%0d: got pc %h flush %b expected 30/0", i, pc, flush); end
      drive(3'b001, 32'h500, 0, 0, 0);
    end
    stall = 0;
    tick();
    checks++; if (pc !== 32'h200 || flush !== 1'b1) begin fails++; $display("FAIL stall_release: got pc %h flush %b expected 200/1", pc, flush); end
    idle();
    tick();
    checks++; if (pc !== 32'h204 || flush !== 1'b0) begin fails++; $display("FAIL stall_after: got pc %h flush %b expected 204/0", pc, flush); end
  endtask

  task automatic test_reset_mid_stall();
    jump(32'h50);
    stall = 1;
    drive(3'b001, 32'h600, 0, 1, 0);
    tick();
    checks++; if (ras_empty !== 1'b0) begin fails++; $display("FAIL stall_push: got empty %b expected 0", ras_empty); end
    do_reset();
    checks++; if (pc !== 32'h0 || ras_empty !== 1'b1 || ras_overflow !== 1'b0) begin fails++; $display("FAIL mid_stall_reset: got pc %h empty %b ovf %b expected 0/1/0", pc, ras_empty, ras_overflow); end
    tick();
    checks++; if (pc !== 32'h4 || flush !== 1'b0) begin fails++; $display("FAIL pending_dropped: got pc %h flush %b expected 4/0", pc, flush); end
  endtask

  task automatic test_call_ret_same();
    jump(32'h80);
    drive(3'b001, 32'h200, 0, 1, 0);
    tick();
    drive(3'b000, 0, 32'h999, 1, 1);
    tick();
    checks++; if (pc !== 32'h84 || ras_empty !== 1'b0) begin fails++; $display("FAIL call_ret_swap: got pc %h empty %b expected 84/0", pc, ras_empty); end
    drive(3'b000, 0, 32'h999, 0, 1);
    tick();
    idle();
    #1;
    checks++; if (pc !== 32'h204 || ras_empty !== 1'b1) begin fails++; $display("FAIL call_ret_return: got pc %h empty %b expected 204/1", pc, ras_empty); end
  endtask

  task automatic test_stats();
    logic [31:0] eb, et;
    do_reset();
    drive(3'b011, 32'h700, 0, 0, 0); sign = 1; tick();
    drive(3'b100, 32'h700, 0, 0, 0); zero = 1; tick();
    drive(3'b101, 32'h700, 0, 0, 0); tick();
    drive(3'b110, 32'h700, 0, 0, 0); carry = 1; tick();
    drive(3'b111, 32'h700, 0, 0, 0); tick();
    drive(3'b001, 32'h700, 0, 0, 0); tick();
    drive(3'b001, 32'h800, 0, 0, 0); tick();
    idle();
`ifdef NPC_BRANCH_STATS_EN
    eb = 5; et = 3;
`else
    eb = 0; et = 0;
`endif
    checks++; if (stat_branches !== eb) begin fails++; $display("FAIL stat_branches: got %0d expected %0d", stat_branches, eb); end
    checks++; if (stat_taken !== et) begin fails++; $display("FAIL stat_taken: got %0d expected %0d", stat_taken, et); end
    checks++; if (pc !== 32'h800) begin fails++; $display("FAIL stats_pc: got %h expected 800", pc); end
  endtask

  initial begin
    test_reset();
    test_cond();
    test_call_ret();
    test_ras_overflow();
    test_stall();
    test_reset_mid_stall();
    test_call_ret_same();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
